// File: rtl/soc_system_bench_pio_pkg.sv
// Shared constants for the benchmark pulse PIO: Avalon word addresses and
// STATUS register bit positions.
package soc_system_bench_pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd1;
  localparam logic [2:0] ADDR_PULSE     = 3'd2;
  localparam logic [2:0] ADDR_STATUS    = 3'd3;
  localparam logic [2:0] ADDR_SET       = 3'd4;
  localparam logic [2:0] ADDR_CLR       = 3'd5;
  localparam logic [2:0] ADDR_TGL       = 3'd6;
  localparam logic [2:0] ADDR_STAMP     = 3'd7;

  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_CNT_LSB  = 16;

endpackage

// File: rtl/soc_system_bench_pulse_timer.sv
// One-shot pulse engine: holds the inversion mask for max(length,1) cycles
// after a trigger; a retrigger ORs in the new mask and reloads the counter.
module soc_system_bench_pulse_timer
  import soc_system_bench_pio_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trigger,
  input  logic [CNT_W-1:0] length,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] pmask,
  output logic [CNT_W-1:0] cnt,
  output logic             busy
);

  logic [CNT_W-1:0] load_val;

  // A zero length behaves as one so the counter never wraps.
  always_comb begin
    load_val = length;
    if (length == '0) load_val = CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pmask <= '0;
      cnt   <= '0;
    end else if (trigger) begin
      pmask <= pmask | mask;
      cnt   <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) pmask <= '0;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/soc_system_bench_pulse_pio.sv
// Avalon-MM output PIO with set/clear/toggle aliases and a hardware pulse engine.
// Define BENCH_PIO_STAMP_EN to add the free-running cycle counter and STAMP register.
module soc_system_bench_pulse_pio
  import soc_system_bench_pio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      CNT_W       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             wr_en;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] data_out;
  logic [CNT_W-1:0] pulse_len;
  logic             trigger;
  logic [WIDTH-1:0] pmask;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign m            = writedata[WIDTH-1:0];
  assign trigger      = wr_en && (address == ADDR_PULSE) && (m != '0);
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= RESET_VALUE;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA: data_out <= m;
        ADDR_SET:  data_out <= data_out | m;
        ADDR_CLR:  data_out <= data_out & ~m;
        ADDR_TGL:  data_out <= data_out ^ m;
        default:   data_out <= data_out;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_len <= CNT_W'(1);
    end else if (wr_en && (address == ADDR_PULSE_LEN)) begin
      pulse_len <= writedata[CNT_W-1:0];
    end
  end

`ifdef BENCH_PIO_STAMP_EN
  logic [31:0] cycle_cnt;
  logic [31:0] stamp;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      stamp     <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (wr_en && ((address == ADDR_DATA) || (address == ADDR_SET) ||
                    (address == ADDR_CLR)  || (address == ADDR_TGL)))
        stamp <= cycle_cnt;
    end
  end
`endif

  soc_system_bench_pulse_timer #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .trigger (trigger),
    .length  (pulse_len),
    .mask    (m),
    .pmask   (pmask),
    .cnt     (cnt),
    .busy    (busy)
  );

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:      readdata[WIDTH-1:0] = data_out;
      ADDR_PULSE_LEN: readdata[CNT_W-1:0] = pulse_len;
      ADDR_PULSE:     readdata[WIDTH-1:0] = pmask;
      ADDR_STATUS: begin
        readdata[STATUS_BUSY_BIT]         = busy;
        readdata[STATUS_CNT_LSB +: CNT_W] = cnt;
      end
`ifdef BENCH_PIO_STAMP_EN
      ADDR_STAMP:     readdata = stamp;
`endif
      default:        readdata = '0;
    endcase
  end

  assign out_port = data_out ^ pmask;

endmodule

// File: tb/tb_soc_system_bench_pulse_pio.sv
// Directed self-checking bench for soc_system_bench_pulse_pio (WIDTH=8, RESET_VALUE=0xA5).
module tb_soc_system_bench_pulse_pio;

  localparam logic [2:0] A_DATA = 3'd0, A_LEN = 3'd1, A_PULSE = 3'd2, A_STAT = 3'd3;
  localparam logic [2:0] A_SET = 3'd4, A_CLR = 3'd5, A_TGL = 3'd6, A_STAMP = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  soc_system_bench_pulse_pio #(
    .WIDTH       (8),
    .CNT_W       (16),
    .RESET_VALUE (8'hA5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a; #1 d = readdata;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    do_reset();
    n_checks++;
    if (out_port !== 8'hA5) begin $display("FAIL reset_out got %h want a5", out_port); n_fail++; end
    rd(A_STAT, r); n_checks++;
    if (r !== 32'h0) begin $display("FAIL reset_status got %h want 0", r); n_fail++; end
    rd(A_LEN, r); n_checks++;
    if (r !== 32'h1) begin $display("FAIL reset_len got %h want 1", r); n_fail++; end
    rd(A_PULSE, r); n_checks++;
    if (r !== 32'h0) begin $display("FAIL reset_pmask got %h want 0", r); n_fail++; end
    rd(A_DATA, r); n_checks++;
    if (r !== 32'hA5) begin $display("FAIL reset_data got %h want a5", r); n_fail++; end
  endtask

  task automatic test_aliases();
    logic [2:0]  addrs [4] = '{A_DATA, A_SET, A_CLR, A_TGL};
    logic [31:0] vals  [4] = '{32'h0F, 32'h30, 32'h01, 32'h81};
    logic [7:0]  exp   [4] = '{8'h0F, 8'h3F, 8'h3E, 8'hBF};
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      wr(addrs[i], vals[i]); n_checks++;
      if (out_port !== exp[i]) begin $display("FAIL alias_step%0d got %h want %h", i, out_port, exp[i]); n_fail++; end
    end
    rd(A_DATA, r); n_checks++;
    if (r !== 32'hBF) begin $display("FAIL alias_readback got %h want bf", r); n_fail++; end
    for (int i = 4; i < 7; i++) begin
      rd(3'(i), r); n_checks++;
      if (r !== 32'h0) begin $display("FAIL wo_read%0d got %h want 0", i, r); n_fail++; end
    end
    wr(A_DATA, 32'hFFFF_FF00); n_checks++;
    if (out_port !== 8'h00) begin $display("FAIL upper_bits_ignored got %h want 00", out_port); n_fail++; end
  endtask

  task automatic test_pulse_len();
    logic [7:0]  exp_o [6] = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h00};
    logic [31:0] exp_s [6] = '{32'h0005_0001, 32'h0004_0001, 32'h0003_0001,
                               32'h0002_0001, 32'h0001_0001, 32'h0000_0000};
    logic [31:0] r;
    wr(A_LEN, 32'd5);
    wr(A_DATA, 32'h00);
    wr(A_PULSE, 32'h04);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      n_checks++;
      if (out_port !== exp_o[k]) begin $display("FAIL pulse5_out k=%0d got %h want %h", k, out_port, exp_o[k]); n_fail++; end
      rd(A_STAT, r); n_checks++;
      if (r !== exp_s[k]) begin $display("FAIL pulse5_status k=%0d got %h want %h", k, r, exp_s[k]); n_fail++; end
    end
  endtask

  task automatic test_retrigger();
    logic [31:0] r;
    wr(A_LEN, 32'd4);
    wr(A_DATA, 32'h00);
    wr(A_PULSE, 32'h01); n_checks++;
    if (out_port !== 8'h01) begin $display("FAIL retrig_first got %h want 01", out_port); n_fail++; end
    @(posedge clk); #1; n_checks++;
    if (out_port !== 8'h01) begin $display("FAIL retrig_second got %h want 01", out_port); n_fail++; end
    wr(A_PULSE, 32'h02); n_checks++;
    if (out_port !== 8'h03) begin $display("FAIL retrig_merge got %h want 03", out_port); n_fail++; end
    rd(A_STAT, r); n_checks++;
    if (r !== 32'h0004_0001) begin $display("FAIL retrig_reload got %h want 00040001", r); n_fail++; end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; n_checks++;
      if (out_port !== 8'h03) begin $display("FAIL retrig_hold%0d got %h want 03", i, out_port); n_fail++; end
    end
    @(posedge clk); #1; n_checks++;
    if (out_port !== 8'h00) begin $display("FAIL retrig_end got %h want 00", out_port); n_fail++; end
  endtask

  task automatic test_same_cycle_priority();
    logic [31:0] r;
    wr(A_DATA, 32'h00);
    wr(A_LEN, 32'd2);
    wr(A_PULSE, 32'h00); n_checks++;
    rd(A_STAT, r);
    if (r !== 32'h0 || out_port !== 8'h00) begin $display("FAIL zero_mask status=%h out=%h want 0/00", r, out_port); n_fail++; end
    wr(A_PULSE, 32'h10);
    @(posedge clk); #1; n_checks++;
    rd(A_STAT, r);
    if (r !== 32'h0001_0001) begin $display("FAIL prio_last_cycle got %h want 00010001", r); n_fail++; end
    wr(A_PULSE, 32'h20); n_checks++;
    if (out_port !== 8'h30) begin $display("FAIL prio_merge got %h want 30", out_port); n_fail++; end
    rd(A_STAT, r); n_checks++;
    if (r !== 32'h0002_0001) begin $display("FAIL prio_reload got %h want 00020001", r); n_fail++; end
    @(posedge clk); #1; @(posedge clk); #1; n_checks++;
    if (out_port !== 8'h00) begin $display("FAIL prio_end got %h want 00", out_port); n_fail++; end
  endtask

  task automatic test_data_during_pulse();
    logic [31:0] r;
    wr(A_LEN, 32'd3);
    wr(A_DATA, 32'h00);
    wr(A_PULSE, 32'h01);
    wr(A_SET, 32'h80); n_checks++;
    if (out_port !== 8'h81) begin $display("FAIL dpulse_set got %h want 81", out_port); n_fail++; end
    wr(A_LEN, 32'd9); n_checks++;
    rd(A_STAT, r);
    if (r !== 32'h0001_0001) begin $display("FAIL dpulse_len_write got %h want 00010001", r); n_fail++; end
    @(posedge clk); #1; n_checks++;
    if (out_port !== 8'h80) begin $display("FAIL dpulse_end got %h want 80", out_port); n_fail++; end
    rd(A_LEN, r); n_checks++;
    if (r !== 32'd9) begin $display("FAIL dpulse_len_read got %h want 9", r); n_fail++; end
  endtask

  task automatic test_len_zero();
    logic [31:0] r;
    wr(A_DATA, 32'h00);
    wr(A_LEN, 32'd0);
    rd(A_LEN, r); n_checks++;
    if (r !== 32'h0) begin $display("FAIL len0_read got %h want 0", r); n_fail++; end
    wr(A_PULSE, 32'hFF); n_checks++;
    if (out_port !== 8'hFF) begin $display("FAIL len0_on got %h want ff", out_port); n_fail++; end
    rd(A_STAT, r); n_checks++;
    if (r !== 32'h0001_0001) begin $display("FAIL len0_status got %h want 00010001", r); n_fail++; end
    @(posedge clk); #1; n_checks++;
    if (out_port !== 8'h00) begin $display("FAIL len0_off got %h want 00", out_port); n_fail++; end
    rd(A_STAT, r); n_checks++;
    if (r !== 32'h0) begin $display("FAIL len0_nowrap got %h want 0", r); n_fail++; end
  endtask

  task automatic test_reset_mid_pulse();
    logic [31:0] r;
    wr(A_DATA, 32'h3C);
    wr(A_LEN, 32'd10);
    wr(A_PULSE, 32'h0F); n_checks++;
    if (out_port !== 8'h33) begin $display("FAIL midrst_pulse got %h want 33", out_port); n_fail++; end
    do_reset(); n_checks++;
    if (out_port !== 8'hA5) begin $display("FAIL midrst_out got %h want a5", out_port); n_fail++; end
    rd(A_STAT, r); n_checks++;
    if (r !== 32'h0) begin $display("FAIL midrst_status got %h want 0", r); n_fail++; end
  endtask

  task automatic test_stamp();
    logic [31:0] r;
    logic [31:0] e1, e2;
`ifdef BENCH_PIO_STAMP_EN
    e1 = 32'd10; e2 = 32'd110;
`else
    e1 = 32'd0;  e2 = 32'd0;
`endif
    do_reset();
    repeat (10) @(posedge clk); #1;
    wr(A_DATA, 32'h11);
    rd(A_STAMP, r); n_checks++;
    if (r !== e1) begin $display("FAIL stamp_first got %0d want %0d", r, e1); n_fail++; end
    repeat (99) @(posedge clk); #1;
    wr(A_DATA, 32'h22);
    rd(A_STAMP, r); n_checks++;
    if (r !== e2) begin $display("FAIL stamp_second got %0d want %0d", r, e2); n_fail++; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_aliases();
    test_pulse_len();
    test_retrigger();
    test_same_cycle_priority();
    test_data_during_pulse();
    test_len_zero();
    test_reset_mid_pulse();
    test_stamp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/soc_system_bench_pulse_pio.md
# soc_system_bench_pulse_pio

Parametrised Avalon-MM output PIO for the benchmark path: a WIDTH-bit output register with atomic set, clear and toggle aliases, plus a hardware one-shot pulse engine. The pulse engine inverts selected output bits for a programmable number of clock cycles with no software involvement in the timing. An optional cycle-stamp register captures a free-running counter on every output update, so HPS software can correlate its writes against fabric time. The block sits on the lightweight HPS-to-FPGA bridge and drives benchmark probe pins or other fabric logic.

## Interface
Parameters:
- WIDTH, 8: output port width, 1..32.
- CNT_W, 16: pulse-length counter width, 1..16.
- RESET_VALUE, 0: reset value of the DATA register, WIDTH bits.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- address  in  3  Avalon word address.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational (readLatency 0).
- out_port  out  WIDTH  output pins, driven as data_out ^ pmask.

## Operation
- A write is accepted when chipselect && !write_n. Unused writedata bits are ignored; unused readdata bits read 0.
- Register map (word address, access, meaning):
  - 0 DATA, RW: write loads data_out; read returns data_out.
  - 1 PULSE_LEN, RW: CNT_W-bit pulse length; reset value 1.
  - 2 PULSE, W: writing mask m with m≠0 sets pmask |= m and loads cnt with max(PULSE_LEN,1). A write of m=0 has no effect. Read returns pmask.
  - 3 STATUS, RO: bit0 = busy (cnt≠0); bits[16+CNT_W-1:16] = cnt.
  - 4 OUTSET, W: data_out |= m.
  - 5 OUTCLEAR, W: data_out &= ~m.
  - 6 OUTTOGGLE, W: data_out ^= m.
  - 7 STAMP, RO: see Configuration.
- Reads of write-only addresses 4, 5 and 6 return 0.
- Pulse engine:
  - While cnt>0, cnt decrements every cycle.
  - On the cycle cnt transitions 1→0, pmask clears.
  - A PULSE write while busy retriggers: the new mask is OR-ed in and cnt reloads.
  - A PULSE write on the same cycle cnt would reach 0 takes priority: cnt reloads, and pmask becomes the new mask OR the old one.
- Writes to DATA, OUTSET, OUTCLEAR and OUTTOGGLE during a pulse update data_out normally. out_port continues to show data_out ^ pmask.
- A PULSE_LEN write during a pulse affects only later triggers.

## Timing
- Reset (synchronous, sampled on the clk edge): data_out=RESET_VALUE, pmask=0, cnt=0, PULSE_LEN=1, stamp and cycle counter=0. out_port therefore equals RESET_VALUE on the first cycle after reset.
- Register write at edge n is visible on out_port and readdata after edge n (1-cycle latency).
- Pulse length: a PULSE write at edge n with PULSE_LEN=L inverts out_port from after edge n through edge n+L, which is exactly max(L,1) cycles.
- Reset asserted mid-pulse aborts the pulse immediately; out_port returns to RESET_VALUE.
- cnt arithmetic is unsigned CNT_W bits. PULSE_LEN=0 is treated as 1 and never wraps cnt.

## Configuration
- BENCH_PIO_STAMP_EN defined:
  - A free-running 32-bit cycle counter increments every clk and wraps 0xFFFFFFFF→0.
  - Any accepted write to addresses 0, 4, 5 or 6 at edge n latches the counter's pre-edge value into stamp.
  - Address 7 reads stamp.
- BENCH_PIO_STAMP_EN undefined: no counter or stamp flops exist, and address 7 reads 0.

## Structure
- Package soc_system_bench_pio_pkg holds:
  - the address constants ADDR_DATA, ADDR_PULSE_LEN, ADDR_PULSE, ADDR_STATUS, ADDR_SET, ADDR_CLR, ADDR_TGL, ADDR_STAMP;
  - the STATUS bit positions.
- One sub-module, soc_system_bench_pulse_timer (inputs: trigger, length, mask; outputs: pmask, cnt, busy), holds the counter and mask logic. The Avalon decode and data register stay in the top level.

## Test plan
- Reset with RESET_VALUE=0xA5 -> out_port=0xA5, STATUS=0, PULSE_LEN reads 1.
- DATA=0x0F, then OUTSET 0x30, OUTCLEAR 0x01, OUTTOGGLE 0x81 -> out_port steps 0x0F, 0x3F, 0x3E, 0xBF, each 1 cycle after its write.
- PULSE_LEN=5, DATA=0x00, PULSE 0x04 -> out_port=0x04 for exactly 5 cycles, then 0x00; STATUS counts 5,4,3,2,1,0.
- PULSE 0x01 with L=4; after 2 cycles PULSE 0x02 -> out_port=0x01, 0x01, then 0x03 for 4 cycles, then 0x00.
- PULSE_LEN=0, PULSE 0xFF -> a single-cycle inversion. Separately, reset asserted mid-pulse -> out_port=RESET_VALUE on the next edge and STATUS=0.
- With BENCH_PIO_STAMP_EN: writes to DATA at cycles 10 and 110 after reset -> STAMP reads 10, then 100 greater. Without the macro, STAMP reads 0.
